// File: rtl/pipe_defs_pkg.sv
// ============================================================================
// pipe_defs : shared definitions for the write-back sequencer slice.
//   - AW_DEF / DW_DEF : default register-address and datapath widths
//   - ysel_t          : RY source select codes carried in every stage record
//   - ysel_is_mem     : helper used by the stall / load-use logic
// Stage record field order (valid, Rdst, wr, ysel) is realised by the
// port list of wb_stage_reg.
// ============================================================================
package pipe_defs;

    localparam int AW_DEF = 5;
    localparam int DW_DEF = 32;

    // 2'b11 is reserved and falls through to the RZ path wherever it is decoded
    typedef enum logic [1:0] {
        YSEL_RZ  = 2'b00,
        YSEL_MEM = 2'b01,
        YSEL_PC  = 2'b10,
        YSEL_RSV = 2'b11
    } ysel_t;

    function automatic logic ysel_is_mem(input logic [1:0] ysel);
        return ysel == YSEL_MEM;
    endfunction

endpackage

// File: rtl/wb_stage_reg.sv
// ============================================================================
// wb_stage_reg : one pipeline stage record {valid, Rdst, wr, ysel}.
//   clk, reset_n       : clock, asynchronous active-low reset (record cleared)
//   i_load             : capture i_valid/i_rdst/i_wr/i_ysel this edge
//   i_bubble           : clear valid this edge (other fields hold); wins over load
//   i_valid..i_ysel    : incoming record
//   o_valid..o_ysel    : registered record
// ============================================================================
module wb_stage_reg
    import pipe_defs::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_load,
    input  logic          i_bubble,
    input  logic          i_valid,
    input  logic [AW-1:0] i_rdst,
    input  logic          i_wr,
    input  logic [1:0]    i_ysel,
    output logic          o_valid,
    output logic [AW-1:0] o_rdst,
    output logic          o_wr,
    output logic [1:0]    o_ysel
);

    logic          r_valid;
    logic [AW-1:0] r_rdst;
    logic          r_wr;
    logic [1:0]    r_ysel;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_rdst  <= '0;
            r_wr    <= 1'b0;
            r_ysel  <= YSEL_RZ;
        end else if (i_bubble) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= i_valid;
            r_rdst  <= i_rdst;
            r_wr    <= i_wr;
            r_ysel  <= i_ysel;
        end
    end

    assign o_valid = r_valid;
    assign o_rdst  = r_rdst;
    assign o_wr    = r_wr;
    assign o_ysel  = r_ysel;

endmodule

// File: rtl/writeback_sequencer.sv
// ============================================================================
// writeback_sequencer : write side of the 32x32 register file.
// Carries destination info through E -> M -> W, builds RY in M, drives the
// register-file write port from W, and produces hazard and memory-wait stall.
//   clk, reset_n              : clock, asynchronous active-low reset
//   issue_valid/Rdst/wr/ysel  : instruction leaving decode
//   issue_Rsrc1/Rsrc2         : decode source addresses (hazard compare)
//   flush                     : kill the instruction entering E
//   RZ_in, PC_Temp            : E-stage results, captured into M
//   MEM_in, mem_ready         : memory data / handshake for MEM-select in M
//   stall, hazard             : pipeline hold / decode bubble requests
//   Rdst, RY, RF_WRITE        : register-file write port
// Build option: define WB_FORWARD_EN to add FWD_A/FWD_B (+ _sel) bypass
// outputs; hazard then only covers load-use and a stalled MEM load in M.
// ============================================================================
module writeback_sequencer
    import pipe_defs::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          issue_valid,
    input  logic [AW-1:0] issue_Rdst,
    input  logic          issue_wr,
    input  logic [1:0]    issue_ysel,
    input  logic [AW-1:0] issue_Rsrc1,
    input  logic [AW-1:0] issue_Rsrc2,
    input  logic          flush,
    input  logic [DW-1:0] RZ_in,
    input  logic [DW-1:0] PC_Temp,
    input  logic [DW-1:0] MEM_in,
    input  logic          mem_ready,
    output logic          stall,
    output logic          hazard,
    output logic [AW-1:0] Rdst,
    output logic [DW-1:0] RY,
    output logic          RF_WRITE
`ifdef WB_FORWARD_EN
    ,
    output logic [DW-1:0] FWD_A,
    output logic [DW-1:0] FWD_B,
    output logic          FWD_A_sel,
    output logic          FWD_B_sel
`endif
);

    logic          w_advance;
    logic          w_e_load_valid;

    logic          w_e_valid, w_m_valid, w_w_valid;
    logic [AW-1:0] w_e_rdst,  w_m_rdst,  w_w_rdst;
    logic          w_e_wr,    w_m_wr,    w_w_wr;
    logic [1:0]    w_e_ysel,  w_m_ysel,  w_w_ysel;

    logic [DW-1:0] r_rz_m;
    logic [DW-1:0] r_pc_m;
    logic [DW-1:0] r_ry_w;
    logic [DW-1:0] w_m_y;

    logic w_e_hit1, w_e_hit2, w_m_hit1, w_m_hit2, w_w_hit1, w_w_hit2;

    // W's ysel has no consumer: RY is already resolved when W loads
    logic w_unused_w_ysel;
    assign w_unused_w_ysel = ^w_w_ysel;

    // Only a MEM-select instruction waiting in M can hold the pipe
    assign w_advance = ~(w_m_valid & ysel_is_mem(w_m_ysel) & ~mem_ready);
    assign stall     = ~w_advance;

    // flush and hazard together still produce a single bubble
    assign w_e_load_valid = issue_valid & ~flush & ~hazard;

    wb_stage_reg #(.AW(AW)) u_stage_e (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_load   (w_advance),
        .i_bubble (1'b0),
        .i_valid  (w_e_load_valid),
        .i_rdst   (issue_Rdst),
        .i_wr     (issue_wr),
        .i_ysel   (issue_ysel),
        .o_valid  (w_e_valid),
        .o_rdst   (w_e_rdst),
        .o_wr     (w_e_wr),
        .o_ysel   (w_e_ysel)
    );

    wb_stage_reg #(.AW(AW)) u_stage_m (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_load   (w_advance),
        .i_bubble (1'b0),
        .i_valid  (w_e_valid),
        .i_rdst   (w_e_rdst),
        .i_wr     (w_e_wr),
        .i_ysel   (w_e_ysel),
        .o_valid  (w_m_valid),
        .o_rdst   (w_m_rdst),
        .o_wr     (w_m_wr),
        .o_ysel   (w_m_ysel)
    );

    // While M waits on memory, W drains to a bubble so no write repeats
    wb_stage_reg #(.AW(AW)) u_stage_w (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_load   (w_advance),
        .i_bubble (~w_advance),
        .i_valid  (w_m_valid),
        .i_rdst   (w_m_rdst),
        .i_wr     (w_m_wr),
        .i_ysel   (w_m_ysel),
        .o_valid  (w_w_valid),
        .o_rdst   (w_w_rdst),
        .o_wr     (w_w_wr),
        .o_ysel   (w_w_ysel)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rz_m <= '0;
            r_pc_m <= '0;
            r_ry_w <= '0;
        end else if (w_advance) begin
            r_rz_m <= RZ_in;
            r_pc_m <= PC_Temp;
            r_ry_w <= w_m_y;
        end
    end

    // RY source mux in M; reserved code 2'b11 takes the RZ path
    always_comb begin
        w_m_y = r_rz_m;
        if (w_m_ysel == YSEL_MEM)
            w_m_y = MEM_in;
        else if (w_m_ysel == YSEL_PC)
            w_m_y = r_pc_m;
    end

    assign Rdst     = w_w_rdst;
    assign RY       = r_ry_w;
    assign RF_WRITE = w_w_valid & w_w_wr & (w_w_rdst != '0);

    // A pending write to R0 never creates a dependence
    function automatic logic src_hit(input logic          valid,
                                     input logic          wr,
                                     input logic [AW-1:0] rdst,
                                     input logic [AW-1:0] src);
        return valid & wr & (rdst != '0) & (rdst == src);
    endfunction

    assign w_e_hit1 = src_hit(w_e_valid, w_e_wr, w_e_rdst, issue_Rsrc1);
    assign w_e_hit2 = src_hit(w_e_valid, w_e_wr, w_e_rdst, issue_Rsrc2);
    assign w_m_hit1 = src_hit(w_m_valid, w_m_wr, w_m_rdst, issue_Rsrc1);
    assign w_m_hit2 = src_hit(w_m_valid, w_m_wr, w_m_rdst, issue_Rsrc2);
    assign w_w_hit1 = src_hit(w_w_valid, w_w_wr, w_w_rdst, issue_Rsrc1);
    assign w_w_hit2 = src_hit(w_w_valid, w_w_wr, w_w_rdst, issue_Rsrc2);

`ifdef WB_FORWARD_EN
    logic [DW-1:0] w_e_y;

    // PC_Temp is ready at end of E just like RZ_in, so a link-register
    // producer in E bypasses its return address rather than the ALU result
    assign w_e_y = (w_e_ysel == YSEL_PC) ? PC_Temp : RZ_in;

    always_comb begin
        FWD_A     = '0;
        FWD_A_sel = 1'b0;
        FWD_B     = '0;
        FWD_B_sel = 1'b0;
        if (issue_valid) begin
            if (w_e_hit1) begin
                FWD_A_sel = 1'b1;
                FWD_A     = w_e_y;
            end else if (w_m_hit1) begin
                FWD_A_sel = 1'b1;
                FWD_A     = w_m_y;
            end else if (w_w_hit1) begin
                FWD_A_sel = 1'b1;
                FWD_A     = r_ry_w;
            end
            if (w_e_hit2) begin
                FWD_B_sel = 1'b1;
                FWD_B     = w_e_y;
            end else if (w_m_hit2) begin
                FWD_B_sel = 1'b1;
                FWD_B     = w_m_y;
            end else if (w_w_hit2) begin
                FWD_B_sel = 1'b1;
                FWD_B     = r_ry_w;
            end
        end
    end

    // A newer producer in E shadows M, so M only matters when E misses
    assign hazard = issue_valid &
        ((w_e_hit1 & ysel_is_mem(w_e_ysel)) |
         (w_e_hit2 & ysel_is_mem(w_e_ysel)) |
         (~w_e_hit1 & w_m_hit1 & ysel_is_mem(w_m_ysel) & stall) |
         (~w_e_hit2 & w_m_hit2 & ysel_is_mem(w_m_ysel) & stall));
`else
    assign hazard = issue_valid &
        (w_e_hit1 | w_e_hit2 | w_m_hit1 | w_m_hit2 | w_w_hit1 | w_w_hit2);
`endif

endmodule

// File: tb/tb_writeback_sequencer.sv
// ============================================================================
// tb_writeback_sequencer : directed bench for writeback_sequencer.
// Each write-producing issue pushes {Rdst, RY, due cycle} to a queue; a
// negedge monitor pops and compares when the due cycle arrives and otherwise
// requires RF_WRITE=0. Combinational outputs are checked #1 after driving.
// ============================================================================
module tb_writeback_sequencer;

    logic        clk;
    logic        reset_n;
    logic        issue_valid;
    logic [4:0]  issue_Rdst;
    logic        issue_wr;
    logic [1:0]  issue_ysel;
    logic [4:0]  issue_Rsrc1;
    logic [4:0]  issue_Rsrc2;
    logic        flush;
    logic [31:0] RZ_in;
    logic [31:0] PC_Temp;
    logic [31:0] MEM_in;
    logic        mem_ready;
    logic        stall;
    logic        hazard;
    logic [4:0]  Rdst;
    logic [31:0] RY;
    logic        RF_WRITE;
`ifdef WB_FORWARD_EN
    logic [31:0] FWD_A;
    logic [31:0] FWD_B;
    logic        FWD_A_sel;
    logic        FWD_B_sel;
`endif

    writeback_sequencer #(.DW(32), .AW(5)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .issue_valid (issue_valid),
        .issue_Rdst  (issue_Rdst),
        .issue_wr    (issue_wr),
        .issue_ysel  (issue_ysel),
        .issue_Rsrc1 (issue_Rsrc1),
        .issue_Rsrc2 (issue_Rsrc2),
        .flush       (flush),
        .RZ_in       (RZ_in),
        .PC_Temp     (PC_Temp),
        .MEM_in      (MEM_in),
        .mem_ready   (mem_ready),
        .stall       (stall),
        .hazard      (hazard),
        .Rdst        (Rdst),
        .RY          (RY),
        .RF_WRITE    (RF_WRITE)
`ifdef WB_FORWARD_EN
        ,
        .FWD_A       (FWD_A),
        .FWD_B       (FWD_B),
        .FWD_A_sel   (FWD_A_sel),
        .FWD_B_sel   (FWD_B_sel)
`endif
    );

    typedef struct {
        logic [4:0]  rdst;
        logic [31:0] ry;
        int unsigned due;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned cyc_n  = 0;
    int          checks = 0;
    int          errors = 0;
    int unsigned c0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Write-port monitor: exact cycle, address and data of every write
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due == cyc_n) begin
            mon_e = sb.pop_front();
            chk("wr_en",   32'(RF_WRITE), 32'd1);
            chk("wr_rdst", 32'(Rdst),     32'(mon_e.rdst));
            chk("wr_ry",   RY,            mon_e.ry);
        end else begin
            chk("no_write", 32'(RF_WRITE), 32'd0);
        end
    end

    task automatic idle();
        issue_valid = 1'b0;
        issue_Rdst  = '0;
        issue_wr    = 1'b0;
        issue_ysel  = 2'b00;
        issue_Rsrc1 = '0;
        issue_Rsrc2 = '0;
        flush       = 1'b0;
        RZ_in       = '0;
        PC_Temp     = '0;
        MEM_in      = '0;
        mem_ready   = 1'b1;
    endtask

    task automatic issue(input logic [4:0] rd, input logic wr, input logic [1:0] ys,
                         input logic [4:0] s1, input logic [4:0] s2, input logic fl);
        issue_valid = 1'b1;
        issue_Rdst  = rd;
        issue_wr    = wr;
        issue_ysel  = ys;
        issue_Rsrc1 = s1;
        issue_Rsrc2 = s2;
        flush       = fl;
    endtask

    task automatic push(input logic [4:0] rd, input logic [31:0] ry, input int unsigned due);
        exp_t e;
        e.rdst = rd;
        e.ry   = ry;
        e.due  = due;
        sb.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        idle();
        #3;
        chk("rst_stall",    32'(stall),    32'd0);
        chk("rst_hazard",   32'(hazard),   32'd0);
        chk("rst_rf_write", 32'(RF_WRITE), 32'd0);
        chk("rst_rdst",     32'(Rdst),     32'd0);
        chk("rst_ry",       RY,            32'd0);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);

        // R5 <- RZ = 0xAA, written three cycles after issue
        c0 = cyc_n;
        issue(5'd5, 1'b1, 2'b00, 5'd0, 5'd0, 1'b0);
        push(5'd5, 32'h0000_00AA, c0 + 3);
        #1 chk("t2_hazard", 32'(hazard), 32'd0);
        @(negedge clk); idle(); RZ_in = 32'h0000_00AA;
        @(negedge clk); idle();
        repeat (3) @(negedge clk);

        // Load R7, memory not ready for two cycles
        c0 = cyc_n;
        issue(5'd7, 1'b1, 2'b01, 5'd0, 5'd0, 1'b0);
        push(5'd7, 32'hDEAD_BEEF, c0 + 5);
        @(negedge clk); idle(); RZ_in = 32'h1111_1111;
        #1 chk("t3_stall_e", 32'(stall), 32'd0);
        @(negedge clk); idle(); mem_ready = 1'b0; MEM_in = 32'h0BAD_0BAD;
        #1 chk("t3_stall1", 32'(stall), 32'd1);
        @(negedge clk); idle(); mem_ready = 1'b0;
        #1 chk("t3_stall2", 32'(stall), 32'd1);
        @(negedge clk); idle(); mem_ready = 1'b1; MEM_in = 32'hDEAD_BEEF;
        #1 chk("t3_stall_end", 32'(stall), 32'd0);
        @(negedge clk); idle();
        repeat (3) @(negedge clk);

        // R0 write is suppressed; source 0 never hazards
        issue(5'd0, 1'b1, 2'b00, 5'd0, 5'd0, 1'b0);
        @(negedge clk); idle(); RZ_in = 32'h0000_1234;
        issue(5'd9, 1'b0, 2'b00, 5'd0, 5'd0, 1'b0);
        #1 chk("t4_src0_hazard", 32'(hazard), 32'd0);
        @(negedge clk); idle();
        repeat (4) @(negedge clk);

        // R3 producer followed by a consumer on Rsrc2
        c0 = cyc_n;
        issue(5'd3, 1'b1, 2'b00, 5'd0, 5'd0, 1'b0);
        push(5'd3, 32'h0000_0033, c0 + 3);
        @(negedge clk); idle(); RZ_in = 32'h0000_0033;
        issue(5'd4, 1'b1, 2'b00, 5'd1, 5'd3, 1'b0);
`ifdef WB_FORWARD_EN
        #1;
        chk("t5_hazard",   32'(hazard),    32'd0);
        chk("t5_fwdb_sel", 32'(FWD_B_sel), 32'd1);
        chk("t5_fwdb",     FWD_B,          32'h0000_0033);
        chk("t5_fwda_sel", 32'(FWD_A_sel), 32'd0);
        push(5'd4, 32'h0000_0044, cyc_n + 3);
`else
        #1 chk("t5_hazard_e", 32'(hazard), 32'd1);
        @(negedge clk); RZ_in = '0;
        #1 chk("t5_hazard_m", 32'(hazard), 32'd1);
        @(negedge clk);
        #1 chk("t5_hazard_w", 32'(hazard), 32'd1);
        @(negedge clk);
        #1 chk("t5_hazard_clr", 32'(hazard), 32'd0);
        push(5'd4, 32'h0000_0044, cyc_n + 3);
`endif
        @(negedge clk); idle(); RZ_in = 32'h0000_0044;
        @(negedge clk); idle();
        repeat (4) @(negedge clk);

        // Flushed issue never writes; older R10 in flight still does
        c0 = cyc_n;
        issue(5'd10, 1'b1, 2'b00, 5'd0, 5'd0, 1'b0);
        push(5'd10, 32'h0000_00A0, c0 + 3);
        @(negedge clk); idle(); RZ_in = 32'h0000_00A0;
        issue(5'd11, 1'b1, 2'b00, 5'd0, 5'd0, 1'b1);
        #1 chk("t6_hazard0", 32'(hazard), 32'd0);
        @(negedge clk); idle(); RZ_in = 32'h0000_00BB;
        issue(5'd12, 1'b1, 2'b00, 5'd10, 5'd0, 1'b1);
`ifndef WB_FORWARD_EN
        #1 chk("t6_flush_hazard", 32'(hazard), 32'd1);
`endif
        @(negedge clk); idle();
        repeat (5) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        // Async reset with three writes in flight (W writing, M, E)
        c0 = cyc_n;
        issue(5'd20, 1'b1, 2'b00, 5'd0, 5'd0, 1'b0);
        push(5'd20, 32'h0000_0020, c0 + 3);
        @(negedge clk); idle(); RZ_in = 32'h0000_0020;
        issue(5'd21, 1'b1, 2'b00, 5'd0, 5'd0, 1'b0);
        push(5'd21, 32'h0000_0021, c0 + 4);
        @(negedge clk); idle(); RZ_in = 32'h0000_0021;
        issue(5'd22, 1'b1, 2'b00, 5'd0, 5'd0, 1'b0);
        push(5'd22, 32'h0000_0022, c0 + 5);
        @(negedge clk); idle(); RZ_in = 32'h0000_0022;
        #2 reset_n = 1'b0;
        sb.delete();
        #1;
        chk("t1_rf_write", 32'(RF_WRITE), 32'd0);
        chk("t1_rdst",     32'(Rdst),     32'd0);
        chk("t1_ry",       RY,            32'd0);
        chk("t1_stall",    32'(stall),    32'd0);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        repeat (6) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
